// File: rtl/operand_fetch_unit_pkg.sv
// Shared constants and helpers for the operand fetch unit and its bypass muxes.
package operand_fetch_unit_pkg;

    localparam int REG_IDX_W    = 5;
    localparam int NUM_REGS     = 32;
    localparam int XLEN_DEFAULT = 32;

    localparam logic [REG_IDX_W-1:0] X0_IDX = '0;

    // x0 is hardwired to zero, so a writeback to it must never be forwarded.
    function automatic logic wb_hits(
        input logic                 wb_en,
        input logic [REG_IDX_W-1:0] wb_addr,
        input logic [REG_IDX_W-1:0] rs
    );
        return wb_en && (wb_addr == rs) && (rs != X0_IDX);
    endfunction

endpackage

// File: rtl/operand_fetch_unit_bypass.sv
// Per-operand source select: fresh RF data or captured forward, held data, then live writeback and x0 rule.
module operand_bypass_mux
    import operand_fetch_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic                 fresh_i,
    input  logic                 fwd_i,
    input  logic [XLEN-1:0]      fwd_data_i,
    input  logic [XLEN-1:0]      rf_rdata_i,
    input  logic [XLEN-1:0]      held_data_i,
    input  logic [REG_IDX_W-1:0] rs_i,
    input  logic                 wb_en_i,
    input  logic [REG_IDX_W-1:0] wb_addr_i,
    input  logic [XLEN-1:0]      wb_data_i,
    output logic [XLEN-1:0]      data_o
);

    logic [XLEN-1:0] base;

    always_comb begin
        base = fresh_i ? (fwd_i ? fwd_data_i : rf_rdata_i) : held_data_i;
        if (rs_i == X0_IDX) begin
            data_o = '0;
        end else if (wb_hits(wb_en_i, wb_addr_i, rs_i)) begin
            data_o = wb_data_i;
        end else begin
            data_o = base;
        end
    end

endmodule

// File: rtl/operand_fetch_unit.sv
// Single-entry operand fetch stage: drives RF read addresses, absorbs the 1-cycle read latency, forwards writebacks.
module operand_fetch_unit
    import operand_fetch_unit_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs1,
    input  logic [REG_IDX_W-1:0] in_rs2,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 flush,
    output logic [REG_IDX_W-1:0] rf_raddr1,
    output logic [REG_IDX_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [XLEN-1:0]      rf_rdata2,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_rs1_data,
    output logic [XLEN-1:0]      out_rs2_data,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic [PAYLOAD_W-1:0] out_payload
);

    logic                 b_valid_q, b_valid_d;
    logic                 fresh_q, fresh_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;
    logic [REG_IDX_W-1:0] rs1_q, rs1_d;
    logic [REG_IDX_W-1:0] rs2_q, rs2_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 fwd1_q, fwd1_d;
    logic                 fwd2_q, fwd2_d;
    logic [XLEN-1:0]      fwd1_data_q, fwd1_data_d;
    logic [XLEN-1:0]      fwd2_data_q, fwd2_data_d;
    logic [XLEN-1:0]      held1_q, held1_d;
    logic [XLEN-1:0]      held2_q, held2_d;
    logic                 accept;

    assign in_ready    = !flush && (!b_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign rf_raddr1   = in_rs1;
    assign rf_raddr2   = in_rs2;
    assign out_valid   = b_valid_q;
    assign out_rd      = rd_q;
    assign out_payload = payload_q;

    operand_bypass_mux #(.XLEN(XLEN)) u_byp1 (
        .fresh_i     (fresh_q),
        .fwd_i       (fwd1_q),
        .fwd_data_i  (fwd1_data_q),
        .rf_rdata_i  (rf_rdata1),
        .held_data_i (held1_q),
        .rs_i        (rs1_q),
        .wb_en_i     (wb_en),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .data_o      (out_rs1_data)
    );

    operand_bypass_mux #(.XLEN(XLEN)) u_byp2 (
        .fresh_i     (fresh_q),
        .fwd_i       (fwd2_q),
        .fwd_data_i  (fwd2_data_q),
        .rf_rdata_i  (rf_rdata2),
        .held_data_i (held2_q),
        .rs_i        (rs2_q),
        .wb_en_i     (wb_en),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .data_o      (out_rs2_data)
    );

    // The RF returns the pre-write value when read and written at the same edge, so that write is captured here.
    always_comb begin
        b_valid_d   = b_valid_q;
        fresh_d     = fresh_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        payload_d   = payload_q;
        fwd1_d      = fwd1_q;
        fwd2_d      = fwd2_q;
        fwd1_data_d = fwd1_data_q;
        fwd2_data_d = fwd2_data_q;
        held1_d     = held1_q;
        held2_d     = held2_q;
        if (flush) begin
            b_valid_d = 1'b0;
            fresh_d   = 1'b0;
        end else if (accept) begin
            b_valid_d   = 1'b1;
            fresh_d     = 1'b1;
            rd_d        = in_rd;
            rs1_d       = in_rs1;
            rs2_d       = in_rs2;
            payload_d   = in_payload;
            fwd1_d      = wb_hits(wb_en, wb_addr, in_rs1);
            fwd2_d      = wb_hits(wb_en, wb_addr, in_rs2);
            fwd1_data_d = wb_data;
            fwd2_data_d = wb_data;
        end else if (b_valid_q && !out_ready) begin
            held1_d = out_rs1_data;
            held2_d = out_rs2_data;
            fresh_d = 1'b0;
        end else if (b_valid_q) begin
            b_valid_d = 1'b0;
            fresh_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid_q   <= 1'b0;
            fresh_q     <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            payload_q   <= '0;
            fwd1_q      <= 1'b0;
            fwd2_q      <= 1'b0;
            fwd1_data_q <= '0;
            fwd2_data_q <= '0;
            held1_q     <= '0;
            held2_q     <= '0;
        end else begin
            b_valid_q   <= b_valid_d;
            fresh_q     <= fresh_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            payload_q   <= payload_d;
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
            fwd1_data_q <= fwd1_data_d;
            fwd2_data_q <= fwd2_data_d;
            held1_q     <= held1_d;
            held2_q     <= held2_d;
        end
    end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: directed vector table, reset corner cases, then random traffic against a queue/array model.
module tb_operand_fetch_unit;
    import operand_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_payload;
    logic        flush;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_data, out_rs2_data;
    logic [4:0]  out_rd;
    logic [31:0] out_payload;

    int testsRun = 0;
    int testsFailed = 0;

    operand_fetch_unit #(.XLEN(32), .PAYLOAD_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_payload(in_payload),
        .flush(flush),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_payload(out_payload)
    );

    always #5 clk = ~clk;

    // Register file environment: synchronous read, old data on same-edge write.
    logic [31:0] rfMem [NUM_REGS];
    always @(posedge clk) begin
        rf_rdata1 <= rfMem[rf_raddr1];
        rf_rdata2 <= rfMem[rf_raddr2];
        if (wb_en) rfMem[wb_addr] <= wb_data;
    end

    typedef struct {
        logic        inValid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] payload;
        logic        wbEn;
        logic [4:0]  wbAddr;
        logic [31:0] wbData;
        logic        outReady, flush;
        logic        expReady, expValid;
        logic [31:0] exp1, exp2;
        logic [4:0]  expRd;
    } vec_t;

    typedef struct {
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] payload;
    } entry_t;

    // Architectural model: register values plus the in-flight request queue.
    logic [31:0] refRegs [NUM_REGS];
    entry_t      pending[$];

    function automatic vec_t mkVec(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                                   input logic [4:0] rd, input logic [31:0] pay, input logic we,
                                   input logic [4:0] wa, input logic [31:0] wd, input logic ordy,
                                   input logic fl, input logic eir, input logic ev,
                                   input logic [31:0] e1, input logic [31:0] e2, input logic [4:0] erd);
        vec_t v;
        v.inValid = iv; v.rs1 = r1; v.rs2 = r2; v.rd = rd; v.payload = pay;
        v.wbEn = we; v.wbAddr = wa; v.wbData = wd; v.outReady = ordy; v.flush = fl;
        v.expReady = eir; v.expValid = ev; v.exp1 = e1; v.exp2 = e2; v.expRd = erd;
        return v;
    endfunction

    function automatic logic [31:0] expOperand(input logic [4:0] rs);
        if (rs == 5'd0) return 32'h0;
        if (wb_en && wb_addr == rs) return wb_data;
        return refRegs[rs];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid   = v.inValid;
        in_rs1     = v.rs1;
        in_rs2     = v.rs2;
        in_rd      = v.rd;
        in_payload = v.payload;
        wb_en      = v.wbEn;
        wb_addr    = v.wbAddr;
        wb_data    = v.wbData;
        out_ready  = v.outReady;
        flush      = v.flush;
    endtask

    task automatic checkOutput();
        logic expReady;
        expReady = !flush && (pending.size() == 0 || out_ready);
        check("in_ready", {31'b0, in_ready}, {31'b0, expReady});
        check("out_valid", {31'b0, out_valid}, {31'b0, pending.size() != 0});
        if (pending.size() != 0 && out_valid) begin
            check("model_rs1", out_rs1_data, expOperand(pending[0].rs1));
            check("model_rs2", out_rs2_data, expOperand(pending[0].rs2));
            check("model_rd", {27'b0, out_rd}, {27'b0, pending[0].rd});
            check("model_payload", out_payload, pending[0].payload);
        end
    endtask

    // One clock: check at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        logic   hs, acc, fl, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        entry_t e;
        @(negedge clk);
        checkOutput();
        hs  = (pending.size() != 0) && out_ready;
        acc = in_valid && !flush && (pending.size() == 0 || out_ready);
        fl  = flush;
        we  = wb_en; wa = wb_addr; wd = wb_data;
        e.rd = in_rd; e.rs1 = in_rs1; e.rs2 = in_rs2; e.payload = in_payload;
        @(posedge clk);
        if (fl) begin
            pending.delete();
        end else begin
            if (hs) void'(pending.pop_front());
            if (acc) pending.push_back(e);
        end
        if (we) refRegs[wa] = wd;
        #1;
    endtask

    vec_t tbl[21];

    initial begin
        rst_n = 1'b0;
        applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check("reset_in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 1; i < NUM_REGS; i++) begin
            wb_en   = 1'b1;
            wb_addr = 5'(i);
            wb_data = (i == 5) ? 32'h11 : (i == 6) ? 32'h22 : 32'h100 + 32'(i);
            tick();
        end
        wb_en = 1'b0;

        //                iv rs1 rs2 rd pay we wa wd       ordy fl eir ev e1        e2        erd
        tbl[0]  = mkVec(1, 5, 6, 7,  1, 0, 0, 0,       1, 0, 1, 0, 0,        0,        0);
        tbl[1]  = mkVec(0, 0, 0, 0,  0, 0, 0, 0,       1, 0, 1, 1, 32'h11,   32'h22,   7);
        tbl[2]  = mkVec(1, 5, 6, 8,  2, 1, 5, 32'hAA,  1, 0, 1, 0, 0,        0,        0);
        tbl[3]  = mkVec(0, 0, 0, 0,  0, 0, 0, 0,       1, 0, 1, 1, 32'hAA,   32'h22,   8);
        tbl[4]  = mkVec(1, 5, 6, 9,  3, 0, 0, 0,       0, 0, 1, 0, 0,        0,        0);
        tbl[5]  = mkVec(0, 0, 0, 0,  0, 0, 0, 0,       0, 0, 0, 1, 32'hAA,   32'h22,   9);
        tbl[6]  = mkVec(0, 0, 0, 0,  0, 1, 6, 32'h55,  0, 0, 0, 1, 32'hAA,   32'h55,   9);
        tbl[7]  = mkVec(0, 0, 0, 0,  0, 0, 0, 0,       0, 0, 0, 1, 32'hAA,   32'h55,   9);
        tbl[8]  = mkVec(0, 0, 0, 0,  0, 0, 0, 0,       1, 0, 1, 1, 32'hAA,   32'h55,   9);
        tbl[9]  = mkVec(1, 0, 0, 1,  4, 1, 0, 32'hFF,  1, 0, 1, 0, 0,        0,        0);
        tbl[10] = mkVec(0, 0, 0, 0,  0, 1, 0, 32'hFF,  1, 0, 1, 1, 0,        0,        1);
        tbl[11] = mkVec(1, 1, 2, 10, 5, 0, 0, 0,       1, 0, 1, 0, 0,        0,        0);
        tbl[12] = mkVec(1, 2, 3, 11, 6, 0, 0, 0,       1, 0, 1, 1, 32'h101,  32'h102,  10);
        tbl[13] = mkVec(1, 3, 4, 12, 7, 0, 0, 0,       1, 0, 1, 1, 32'h102,  32'h103,  11);
        tbl[14] = mkVec(1, 4, 1, 13, 8, 0, 0, 0,       1, 0, 1, 1, 32'h103,  32'h104,  12);
        tbl[15] = mkVec(0, 0, 0, 0,  0, 0, 0, 0,       1, 0, 1, 1, 32'h104,  32'h101,  13);
        tbl[16] = mkVec(1, 1, 2, 14, 9, 0, 0, 0,       0, 0, 1, 0, 0,        0,        0);
        tbl[17] = mkVec(1, 3, 3, 15, 10, 0, 0, 0,      0, 1, 0, 1, 32'h101,  32'h102,  14);
        tbl[18] = mkVec(0, 0, 0, 0,  0, 0, 0, 0,       1, 0, 1, 0, 0,        0,        0);
        tbl[19] = mkVec(1, 3, 3, 16, 11, 1, 3, 32'h333, 1, 0, 1, 0, 0,       0,        0);
        tbl[20] = mkVec(0, 0, 0, 0,  0, 0, 0, 0,       1, 0, 1, 1, 32'h333,  32'h333,  16);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            #2;
            check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].expReady});
            check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].expValid});
            if (tbl[i].expValid) begin
                check($sformatf("vec%0d_rs1", i), out_rs1_data, tbl[i].exp1);
                check($sformatf("vec%0d_rs2", i), out_rs2_data, tbl[i].exp2);
                check($sformatf("vec%0d_rd", i), {27'b0, out_rd}, {27'b0, tbl[i].expRd});
            end
            tick();
        end

        // Asynchronous reset in the middle of a stall drops out_valid without waiting for an edge.
        applyStimulus(mkVec(1, 1, 2, 20, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midstall_reset_out_valid", {31'b0, out_valid}, 32'h0);
        check("midstall_reset_in_ready", {31'b0, in_ready}, 32'h1);
        pending.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int n = 0; n < 600; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_rs1     = 5'($urandom_range(0, 7));
            in_rs2     = 5'($urandom_range(0, 7));
            in_rd      = 5'($urandom_range(0, 31));
            in_payload = $urandom;
            wb_en      = $urandom_range(0, 1) == 1;
            wb_addr    = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            out_ready  = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Requester side of the 2-read/1-write, 32x32 register file.
- Accepts decoded instructions over a valid/ready handshake and drives the register file read addresses.
- Absorbs the register file's 1-cycle synchronous read latency and presents both source operands, with payload, on a registered valid/ready output.
- Forwards same-cycle and later writebacks so operands are never stale; x0 always reads zero.

Parameters:
- XLEN, 32, operand/data width; must match the register file data width.
- PAYLOAD_W, 32, width of opaque instruction payload passed through unchanged.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  unit can accept this cycle.
- in_rs1  in  5  source register 1 index.
- in_rs2  in  5  source register 2 index.
- in_rd  in  5  destination index, passed through.
- in_payload  in  PAYLOAD_W  opaque instruction bits, passed through.
- flush  in  1  discard the held entry and block acceptance this cycle.
- rf_raddr1  out  5  register file read port 1 address.
- rf_raddr2  out  5  register file read port 2 address.
- rf_rdata1  in  XLEN  register file read data 1, valid the cycle after the address.
- rf_rdata2  in  XLEN  register file read data 2, same timing as rf_rdata1.
- wb_en  in  1  writeback enable, same signal as the register file write enable.
- wb_addr  in  5  writeback register index.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  operands valid.
- out_ready  in  1  downstream accepts.
- out_rs1_data  out  XLEN  operand 1.
- out_rs2_data  out  XLEN  operand 2.
- out_rd  out  5  passed-through destination index.
- out_payload  out  PAYLOAD_W  passed-through payload.

Behaviour:
- Reset (async, rst_n=0):
  - b_valid=0 and out_valid=0.
  - Held operands, rd, rs indices and payload cleared to 0.
  - fresh flag = 0.
- Single holding stage B, plus request decode:
  - in_ready = !flush && (!b_valid || out_ready).
  - Accept = in_valid && in_ready.
- Address drive:
  - rf_raddr1/2 = in_rs1/in_rs2 combinationally every cycle.
  - The register file samples them at the same edge that accepts the request.
- Latency and throughput:
  - Accept at edge N gives out_valid=1 from edge N; operands on out_* in the cycle after acceptance.
  - Sustained throughput is 1 per cycle when out_ready=1.
- On accept:
  - Stage B captures rd, payload, rs1, rs2 and sets fresh=1.
  - It also captures a per-operand forward bit and wb_data when wb_en && wb_addr==rs && rs!=0 in the accept cycle. The register file returns the old value in that case.
- Operand source while b_valid:
  - fresh=1: base = fwd ? fwd_data : rf_rdata.
  - fresh=0: base = held register.
- Output bypass:
  - out_rsN_data = (wb_en && wb_addr==rsN && rsN!=0) ? wb_data : base.
  - Forced to 0 when rsN==0.
- Stall (out_valid && !out_ready):
  - Next edge loads held registers with the current out_rsN_data and clears fresh.
  - Writebacks during the stall therefore update held operands.
- Output handshake:
  - out_valid && out_ready with no new accept clears b_valid.
  - With a new accept, B reloads in the same edge; there is no bubble.
- flush: next edge b_valid=0 and fresh=0; no accept in the flush cycle (in_ready=0).
- Simultaneous events:
  - Writeback to rs1 and rs2 with the same index forwards to both.
  - Writeback to x0 is never forwarded.
- Outputs other than valid/ready hold their last value when out_valid=0; the bench ignores them.

Decomposition:
- Shared package: REG_IDX_W=5, NUM_REGS=32, XLEN default, and the x0 index constant.
- Natural sub-module: operand_bypass_mux.
  - Instantiated once per operand.
  - Selects rf_rdata, captured forward data, held data and the live writeback.
  - Applies the x0 zero rule.

Test Plan:
- Register file preloaded with x5=0x11, x6=0x22; request rs1=5, rs2=6, rd=7, out_ready=1 -> next cycle out_valid=1, operands 0x11/0x22, out_rd=7.
- Accept rs1=5 in the same cycle as wb_en=1, wb_addr=5, wb_data=0xAA -> out_rs1_data=0xAA, not 0x11.
- Entry held with out_ready=0 for 3 cycles; wb writes x6=0x55 in cycle 2 -> on release out_rs2_data=0x55.
- rs1=0, rs2=0 with wb_en to x0, data 0xFF -> both operands 0.
- Back-to-back 4 requests with out_ready=1 -> 4 outputs in 4 consecutive cycles, in order, in_ready never drops.
- Entry valid, flush=1 with in_valid=1 -> in_ready=0, next cycle out_valid=0. Asserting rst_n=0 mid-stall -> out_valid=0 immediately.
